// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t    : responder FSM states (IDLE / WAIT / RESP)
//   WORD_BYTES : bytes per stored word
//   BYTE_OFS   : byte-offset bits below the word index
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_OFS   = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: DEPTH_WORDS x 32 bits.
// Synchronous write, asynchronous read, contents never reset.
// Ports:
//   clock   : write clock
//   we_i    : write enable
//   addr_i  : word index (shared by read and write)
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clock,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with fixed response latency.
// A request is accepted in IDLE, held for WAIT_CYCLES cycles, and completed
// with a one-cycle resp_valid pulse (RESP). Stores commit on the RESP edge.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are not
// committed, return 0, and raise a sticky err; otherwise err is tied low and
// the low address bits are ignored.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   req_valid/we/addr/wdata : request (byte address, store data)
//   req_ready             : high in IDLE only
//   resp_valid/resp_rdata : completion pulse and load data (0 otherwise)
//   stall                 : pipeline hold request
//   err                   : sticky misaligned-access flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            accept;
  logic            commit;
  logic [31:0]     arr_rdata;
  logic            rdata_en;
  logic            unused_addr;

  assign accept = req_valid & req_ready;

  // Address bits above the wrapped index (and the byte offset in the
  // non-trapping build) do not take part in the access.
  assign unused_addr = ^{req_addr[31:AW+BYTE_OFS], req_addr[BYTE_OFS-1:0]};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[AW+BYTE_OFS-1:BYTE_OFS];
        wdata_q <= req_wdata;
      end
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;
  logic err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        mis_q <= |req_addr[BYTE_OFS-1:0];
      end
      if ((state_q == RESP) && mis_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign commit   = (state_q == RESP) & we_q & ~mis_q;
  assign rdata_en = (state_q == RESP) & ~we_q & ~mis_q;
  assign err      = err_q;
`else
  assign commit   = (state_q == RESP) & we_q;
  assign rdata_en = (state_q == RESP) & ~we_q;
  assign err      = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock   (clock),
    .we_i    (commit),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // Outputs
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    stall      = ((state_q == IDLE) & req_valid) | (state_q == WAIT);
    resp_rdata = rdata_en ? arr_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses
// WAIT_CYCLES=0. A cycle-numbered transaction model predicts every output on
// every cycle; directed sequences add hand-computed literal expectations.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int W0    = 2;
  localparam int W1    = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        rv  [2];
  logic        rwe [2];
  logic [31:0] ra  [2];
  logic [31:0] rwd [2];
  logic        rdy [2];
  logic        rsp [2];
  logic        stl [2];
  logic        er  [2];
  logic [31:0] rdt [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
    .clock(clk), .reset(rst[0]), .req_valid(rv[0]), .req_we(rwe[0]),
    .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(rdy[0]),
    .resp_valid(rsp[0]), .resp_rdata(rdt[0]), .stall(stl[0]), .err(er[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .clock(clk), .reset(rst[1]), .req_valid(rv[1]), .req_we(rwe[1]),
    .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(rdy[1]),
    .resp_valid(rsp[1]), .resp_rdata(rdt[1]), .stall(stl[1]), .err(er[1]));

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, i, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Each accepted request at cycle c responds at cycle c+W+1; the responder is
  // busy from acceptance through the response cycle.
  int          cyc    [2] = '{0, 0};
  int          rcyc   [2] = '{-1, -1};
  bit          m_we   [2];
  bit          m_mis  [2];
  int          m_idx  [2];
  logic [31:0] m_wd   [2];
  logic [31:0] mem    [2][DEPTH];
  bit          known  [2][DEPTH];
  bit          m_err  [2] = '{0, 0};
  int          m_nrsp [2] = '{0, 0};
  int          d_nrsp [2] = '{0, 0};

  function automatic int wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic bit busy(input int i);
    return rcyc[i] >= cyc[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        rcyc[i]  = -1;
        m_err[i] = 1'b0;
      end else if (busy(i)) begin
        if (cyc[i] == rcyc[i]) begin
          m_nrsp[i]++;
          if (m_we[i] && !(TRAP && m_mis[i])) begin
            mem[i][m_idx[i]]   = m_wd[i];
            known[i][m_idx[i]] = 1'b1;
          end
          if (TRAP && m_mis[i]) m_err[i] = 1'b1;
        end
      end else if (rv[i]) begin
        rcyc[i]  = cyc[i] + wait_of(i) + 1;
        m_we[i]  = rwe[i];
        m_idx[i] = int'((ra[i] >> 2) % DEPTH);
        m_wd[i]  = rwd[i];
        m_mis[i] = (ra[i][1:0] != 2'b00);
      end
      cyc[i]++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit b, r;
        b = busy(i);
        r = b && (cyc[i] == rcyc[i]);
        if (rsp[i] === 1'b1) d_nrsp[i]++;
        chk("req_ready", i, {31'd0, rdy[i]}, {31'd0, !b});
        chk("resp_valid", i, {31'd0, rsp[i]}, {31'd0, r});
        chk("stall", i, {31'd0, stl[i]}, {31'd0, (!b && rv[i]) || (b && !r)});
        chk("err", i, {31'd0, er[i]}, {31'd0, m_err[i]});
        if (!r)
          chk("rdata_idle", i, rdt[i], 32'd0);
        else if (!m_we[i] && TRAP && m_mis[i])
          chk("rdata_trap", i, rdt[i], 32'd0);
        else if (!m_we[i] && known[i][m_idx[i]])
          chk("rdata_load", i, rdt[i], mem[i][m_idx[i]]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Issue one request (starting just after an edge, responder idle), hold it
  // valid through the response cycle, and report latency (cycles from the
  // accept cycle to resp_valid), stall-high cycles and returned data.
  task automatic access(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int stalls, output logic [31:0] data);
    rv[i] = 1'b1; rwe[i] = we; ra[i] = a; rwd[i] = d;
    lat = -1; stalls = 0; data = 'x;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (stl[i] === 1'b1) stalls++;
      if (rsp[i] === 1'b1) begin
        lat  = k;
        data = rdt[i];
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL resp_timeout[%0d]: got no resp_valid expected one within 20 cycles", i);
    end
    sync();
    rv[i] = 1'b0;
  endtask

  int          lat, stalls, cnt;
  logic [31:0] data;
  logic        pat_rsp [4];
  logic        pat_stl [4];
  logic [31:0] pat_dat [4];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rv[i] = 1'b0; rwe[i] = 1'b0; ra[i] = '0; rwd[i] = '0;
    end
    sync();
    chk_en = 1'b1;
    sync();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", i, {31'd0, rdy[i]}, 32'd1);
      chk("rst_resp", i, {31'd0, rsp[i]}, 32'd0);
      chk("rst_rdata", i, rdt[i], 32'd0);
      chk("rst_stall", i, {31'd0, stl[i]}, 32'd0);
      chk("rst_err", i, {31'd0, er[i]}, 32'd0);
    end
    sync();

    // Store then load at 0x10, WAIT_CYCLES=2
    access(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, stalls, data);
    chk("st_latency", 0, lat, 3);
    chk("st_stalls", 0, stalls, 3);
    access(0, 1'b0, 32'h10, 32'h0, lat, stalls, data);
    chk("ld_latency", 0, lat, 3);
    chk("ld_stalls", 0, stalls, 3);
    chk("ld_data", 0, data, 32'hDEADBEEF);

    // Address wrap: 0x100 aliases word 0 with 64 words
    access(0, 1'b1, 32'h100, 32'h1234, lat, stalls, data);
    access(0, 1'b0, 32'h0, 32'h0, lat, stalls, data);
    chk("wrap_data", 0, data, 32'h1234);

    // Reset during WAIT aborts the store
    access(0, 1'b1, 32'h8, 32'h5555, lat, stalls, data);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 32'h8; rwd[0] = 32'hAAAA;
    cnt = 0;
    @(negedge clk); if (rsp[0] === 1'b1) cnt++;
    sync();
    rv[0] = 1'b0; rst[0] = 1'b1;
    @(negedge clk); if (rsp[0] === 1'b1) cnt++;
    sync();
    rst[0] = 1'b0;
    repeat (4) begin
      @(negedge clk); if (rsp[0] === 1'b1) cnt++;
    end
    chk("abort_no_resp", 0, cnt, 0);
    sync();
    access(0, 1'b0, 32'h8, 32'h0, lat, stalls, data);
    chk("abort_data", 0, data, 32'h5555);

    // Misaligned accesses
    access(0, 1'b1, 32'h4, 32'h1111, lat, stalls, data);
    access(0, 1'b1, 32'h6, 32'h2222, lat, stalls, data);
    chk("mis_latency", 0, lat, 3);
    @(negedge clk);
    chk("mis_err", 0, {31'd0, er[0]}, TRAP ? 32'd1 : 32'd0);
    sync();
    access(0, 1'b0, 32'h4, 32'h0, lat, stalls, data);
    chk("mis_word", 0, data, TRAP ? 32'h1111 : 32'h2222);
    access(0, 1'b0, 32'h6, 32'h0, lat, stalls, data);
    chk("mis_load", 0, data, TRAP ? 32'h0 : 32'h2222);
    chk("mis_err_held", 0, {31'd0, er[0]}, TRAP ? 32'd1 : 32'd0);
    rst[0] = 1'b1;
    sync();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("err_cleared", 0, {31'd0, er[0]}, 32'd0);
    sync();

    // WAIT_CYCLES=0: preload, then back-to-back loads held valid
    access(1, 1'b1, 32'h0, 32'hA0A00000, lat, stalls, data);
    chk("w0_latency", 1, lat, 1);
    chk("w0_stalls", 1, stalls, 1);
    access(1, 1'b1, 32'h4, 32'hB4B4, lat, stalls, data);
    rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat_rsp[k] = rsp[1]; pat_stl[k] = stl[1]; pat_dat[k] = rdt[1];
      if (k == 1) begin
        sync();
        ra[1] = 32'h4;
      end
    end
    sync();
    rv[1] = 1'b0;
    chk("b2b_rsp", 1, {28'd0, pat_rsp[0], pat_rsp[1], pat_rsp[2], pat_rsp[3]}, 32'b0101);
    chk("b2b_stall", 1, {28'd0, pat_stl[0], pat_stl[1], pat_stl[2], pat_stl[3]}, 32'b1010);
    chk("b2b_data0", 1, pat_dat[1], 32'hA0A00000);
    chk("b2b_data1", 1, pat_dat[3], 32'hB4B4);

    repeat (3) @(negedge clk);
    // One response per request despite req_valid held through RESP
    chk("resp_count_dut", 0, d_nrsp[0], 10);
    chk("resp_count_dut", 1, d_nrsp[1], 4);
    chk("resp_count_model", 0, m_nrsp[0], 10);
    chk("resp_count_model", 1, m_nrsp[1], 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
